arf_access_sequencer: RTL and testbench

- Bus-master sequencer that drives the control side of the address register file (PC/SP/AR) and a byte-wide memory.
- Executes multi-cycle address-register operations on request from the control unit: instruction fetch, 16-bit stack push and pop, PC load, and SP load.
- Sits between the control unit, the address register file (ARF) and the memory. It decides RegSel, FunSel and OutCSel every cycle, and uses ARF OutC as the memory address.

---
 rtl/arf_access_sequencer.sv | 148 ++++++++++++++
 tb/tb_arf_access_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arf_access_sequencer.sv
// Address-register-file access sequencer: runs fetch, 16-bit push/pop and PC/SP loads
// by steering ARF enables/function/output select and a byte-wide memory.
//
// state  | meaning
// IDLE   | waiting for start; latches wdata/load_addr on accept
// F_LO   | read instruction low byte at PC, PC++
// F_HI   | read instruction high byte at PC, PC++
// P_DEC1 | SP-- ahead of high-byte write
// P_WHI  | write wdata[15:8] at SP
// P_DEC2 | SP-- ahead of low-byte write
// P_WLO  | write wdata[7:0] at SP
// R_LO   | read pop low byte at SP, SP++
// R_HI   | read pop high byte at SP, SP++
// J_LD   | load PC from load_addr
// S_LD   | load SP from load_addr
// DONE   | one-cycle completion pulse
module arf_access_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] wdata,
  input  logic [15:0] load_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] ir,
  output logic [15:0] pop_data,
  output logic [31:0] arf_i,
  output logic [2:0]  arf_reg_sel,
  output logic [1:0]  arf_fun_sel,
  output logic [1:0]  arf_out_c_sel,
  output logic [1:0]  arf_out_d_sel,
  input  logic [15:0] arf_out_c,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [3:0] {
    IDLE, F_LO, F_HI, P_DEC1, P_WHI, P_DEC2, P_WLO, R_LO, R_HI, J_LD, S_LD, DONE
  } state_t;

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] SEL_PC   = 2'b00;
  localparam logic [1:0] SEL_SP   = 2'b01;

  state_t      state, state_nxt;
  logic [15:0] wdata_q, load_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wdata_q     <= 16'h0;
      load_addr_q <= 16'h0;
      ir          <= 16'h0;
      pop_data    <= 16'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        wdata_q     <= wdata;
        load_addr_q <= load_addr;
      end
      case (state)
        F_LO:    ir[7:0]        <= mem_rdata;
        F_HI:    ir[15:8]       <= mem_rdata;
        R_LO:    pop_data[7:0]  <= mem_rdata;
        R_HI:    pop_data[15:8] <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so an async reset clears them in the same cycle.
  always_comb begin
    state_nxt     = state;
    arf_reg_sel   = 3'b000;
    arf_fun_sel   = FUN_DEC;
    arf_out_c_sel = SEL_PC;
    arf_i         = 32'h0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_wdata     = 8'h0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000:  state_nxt = F_LO;
            3'b001:  state_nxt = P_DEC1;
            3'b010:  state_nxt = R_LO;
            3'b011:  state_nxt = J_LD;
            3'b100:  state_nxt = S_LD;
            default: state_nxt = DONE;
          endcase
        end
      end
      F_LO, F_HI: begin
        mem_en      = 1'b1;
        arf_reg_sel = 3'b100;
        arf_fun_sel = FUN_INC;
        state_nxt   = (state == F_LO) ? F_HI : DONE;
      end
      P_DEC1, P_DEC2: begin
        arf_reg_sel = 3'b010;
        arf_fun_sel = FUN_DEC;
        state_nxt   = (state == P_DEC1) ? P_WHI : P_WLO;
      end
      P_WHI: begin
        arf_out_c_sel = SEL_SP;
        mem_en        = 1'b1;
        mem_wr        = 1'b1;
        mem_wdata     = wdata_q[15:8];
        state_nxt     = P_DEC2;
      end
      P_WLO: begin
        arf_out_c_sel = SEL_SP;
        mem_en        = 1'b1;
        mem_wr        = 1'b1;
        mem_wdata     = wdata_q[7:0];
        state_nxt     = DONE;
      end
      R_LO, R_HI: begin
        arf_out_c_sel = SEL_SP;
        mem_en        = 1'b1;
        arf_reg_sel   = 3'b010;
        arf_fun_sel   = FUN_INC;
        state_nxt     = (state == R_LO) ? R_HI : DONE;
      end
      J_LD, S_LD: begin
        arf_i       = {16'h0, load_addr_q};
        arf_reg_sel = (state == J_LD) ? 3'b100 : 3'b010;
        arf_fun_sel = FUN_LOAD;
        state_nxt   = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = (state != IDLE) && (state != DONE);
  assign done          = (state == DONE);
  assign mem_addr      = arf_out_c;
  assign arf_out_d_sel = 2'b00;

endmodule

// File: tb/tb_arf_access_sequencer.sv
// Directed bench for arf_access_sequencer with a behavioural ARF (PC/SP/AR) and a 64 KiB byte memory.
module tb_arf_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] wdata, load_addr;
  logic        busy, done;
  logic [15:0] ir, pop_data;
  logic [31:0] arf_i;
  logic [2:0]  arf_reg_sel;
  logic [1:0]  arf_fun_sel, arf_out_c_sel, arf_out_d_sel;
  logic [15:0] arf_out_c, mem_addr;
  logic        mem_en, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;

  int compared = 0;
  int mismatched = 0;
  int wr_cnt = 0;

  logic [15:0] pc = 16'h0, sp = 16'h0, ar = 16'h5A5A;
  logic [7:0]  mem [0:65535];

  arf_access_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .wdata(wdata), .load_addr(load_addr),
    .busy(busy), .done(done), .ir(ir), .pop_data(pop_data), .arf_i(arf_i),
    .arf_reg_sel(arf_reg_sel), .arf_fun_sel(arf_fun_sel), .arf_out_c_sel(arf_out_c_sel),
    .arf_out_d_sel(arf_out_d_sel), .arf_out_c(arf_out_c), .mem_addr(mem_addr),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] arf_fn(input logic [1:0] fs, input logic [15:0] v, input logic [15:0] ld);
    case (fs)
      2'b00:   return v - 16'd1;
      2'b01:   return v + 16'd1;
      2'b10:   return ld;
      default: return 16'h0;
    endcase
  endfunction

  // ARF model: not reset by the sequencer's reset
  always @(posedge clk) begin
    if (arf_reg_sel[2]) pc <= arf_fn(arf_fun_sel, pc, arf_i[15:0]);
    if (arf_reg_sel[1]) sp <= arf_fn(arf_fun_sel, sp, arf_i[15:0]);
    if (arf_reg_sel[0]) ar <= arf_fn(arf_fun_sel, ar, arf_i[15:0]);
    if (mem_en && mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt++;
    end
  end

  always_comb begin
    case (arf_out_c_sel)
      2'b00:   arf_out_c = pc;
      2'b01:   arf_out_c = sp;
      default: arf_out_c = ar;
    endcase
  end

  assign mem_rdata = mem[mem_addr];

  // Issues one operation; returns cycle (1-based after the start edge) where done is seen
  // and the number of busy cycles before it. Leaves the sequencer back in IDLE.
  task automatic run_op(input logic [2:0] o, input logic [15:0] wd, input logic [15:0] la,
                        output int lat, output int nbusy);
    op = o; wdata = wd; load_addr = la; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; nbusy = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) nbusy++;
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; op = 3'b001; wdata = 16'hFFFF; load_addr = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({busy, done} !== 2'b00) begin
      mismatched++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    compared++;
    if ({arf_reg_sel, arf_fun_sel, arf_out_c_sel, arf_out_d_sel} !== 9'h0) begin
      mismatched++; $display("FAIL reset_arf_ctrl: got %h expected 000", {arf_reg_sel, arf_fun_sel, arf_out_c_sel, arf_out_d_sel});
    end
    compared++;
    if ({arf_i, mem_en, mem_wr, mem_wdata} !== 42'h0) begin
      mismatched++; $display("FAIL reset_bus: got %h expected 0", {arf_i, mem_en, mem_wr, mem_wdata});
    end
    compared++;
    if ({ir, pop_data} !== 32'h0) begin
      mismatched++; $display("FAIL reset_regs: got %h expected 0", {ir, pop_data});
    end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_jump();
    int lat, nb;
    run_op(3'b011, 16'h0, 16'h0040, lat, nb);
    compared++;
    if (lat !== 2) begin mismatched++; $display("FAIL jump_latency: got %0d expected 2", lat); end
    compared++;
    if (nb !== 1) begin mismatched++; $display("FAIL jump_busy: got %0d expected 1", nb); end
    compared++;
    if (pc !== 16'h0040) begin mismatched++; $display("FAIL jump_pc: got %h expected 0040", pc); end
    compared++;
    if (ar !== 16'h5A5A) begin mismatched++; $display("FAIL jump_ar: got %h expected 5a5a", ar); end
  endtask

  task automatic test_fetch();
    int lat, nb;
    mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
    run_op(3'b000, 16'h0, 16'h0, lat, nb);
    compared++;
    if (lat !== 3) begin mismatched++; $display("FAIL fetch_latency: got %0d expected 3", lat); end
    compared++;
    if (ir !== 16'h1234) begin mismatched++; $display("FAIL fetch_ir: got %h expected 1234", ir); end
    compared++;
    if (pc !== 16'h0042) begin mismatched++; $display("FAIL fetch_pc: got %h expected 0042", pc); end
  endtask

  task automatic test_push();
    int lat, nb, w0;
    run_op(3'b100, 16'h0, 16'h0100, lat, nb);
    compared++;
    if (lat !== 2 || sp !== 16'h0100) begin
      mismatched++; $display("FAIL setsp: got lat %0d sp %h expected lat 2 sp 0100", lat, sp);
    end
    w0 = wr_cnt;
    run_op(3'b001, 16'hBEEF, 16'h0, lat, nb);
    compared++;
    if (lat !== 5) begin mismatched++; $display("FAIL push_latency: got %0d expected 5", lat); end
    compared++;
    if ({mem[16'h00FF], mem[16'h00FE]} !== 16'hBEEF) begin
      mismatched++; $display("FAIL push_mem: got %h%h expected beef", mem[16'h00FF], mem[16'h00FE]);
    end
    compared++;
    if (sp !== 16'h00FE) begin mismatched++; $display("FAIL push_sp: got %h expected 00fe", sp); end
    compared++;
    if (wr_cnt - w0 !== 2) begin mismatched++; $display("FAIL push_writes: got %0d expected 2", wr_cnt - w0); end
  endtask

  task automatic test_pop_ignore_start();
    int w0;
    bit seen_busy;
    w0 = wr_cnt;
    op = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    op = 3'b001; wdata = 16'h7777;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (done !== 1'b1) begin mismatched++; $display("FAIL pop_done: got %b expected 1", done); end
    seen_busy = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy) seen_busy = 1;
    end
    compared++;
    if (pop_data !== 16'hBEEF) begin mismatched++; $display("FAIL pop_data: got %h expected beef", pop_data); end
    compared++;
    if (sp !== 16'h0100) begin mismatched++; $display("FAIL pop_sp: got %h expected 0100", sp); end
    compared++;
    if (seen_busy !== 1'b0 || wr_cnt !== w0) begin
      mismatched++; $display("FAIL ignored_start: got busy %b writes %0d expected busy 0 writes 0", seen_busy, wr_cnt - w0);
    end
  endtask

  task automatic test_wrap_fetch();
    int lat, nb;
    run_op(3'b011, 16'h0, 16'hFFFF, lat, nb);
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    run_op(3'b000, 16'h0, 16'h0, lat, nb);
    compared++;
    if (ir !== 16'hABCD) begin mismatched++; $display("FAIL wrap_ir: got %h expected abcd", ir); end
    compared++;
    if (pc !== 16'h0001) begin mismatched++; $display("FAIL wrap_pc: got %h expected 0001", pc); end
  endtask

  task automatic test_nop();
    int lat, nb;
    run_op(3'b110, 16'h0, 16'h0, lat, nb);
    compared++;
    if (lat !== 1 || nb !== 0) begin
      mismatched++; $display("FAIL nop: got lat %0d busy %0d expected lat 1 busy 0", lat, nb);
    end
    compared++;
    if (ir !== 16'hABCD || pc !== 16'h0001) begin
      mismatched++; $display("FAIL nop_hold: got ir %h pc %h expected abcd 0001", ir, pc);
    end
  endtask

  task automatic test_reset_mid_push();
    int lat, nb, w0;
    run_op(3'b100, 16'h0, 16'h0100, lat, nb);
    w0 = wr_cnt;
    op = 3'b001; wdata = 16'h1122; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    compared++;
    if ({mem_en, mem_wr, mem_wdata} !== {2'b11, 8'h11}) begin
      mismatched++; $display("FAIL whi_drive: got %b%b %h expected 11 11", mem_en, mem_wr, mem_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({busy, done, mem_en, mem_wr, mem_wdata, arf_reg_sel, arf_fun_sel, arf_out_c_sel} !== 19'h0) begin
      mismatched++; $display("FAIL async_reset_outputs: got %h expected 0", {busy, done, mem_en, mem_wr, mem_wdata, arf_reg_sel, arf_fun_sel, arf_out_c_sel});
    end
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL after_reset_busy: got %b expected 0", busy); end
    compared++;
    if (sp !== 16'h00FF) begin mismatched++; $display("FAIL after_reset_sp: got %h expected 00ff", sp); end
    compared++;
    if (wr_cnt !== w0 || mem[16'h00FF] !== 8'hBE) begin
      mismatched++; $display("FAIL aborted_write: got writes %0d mem %h expected 0 be", wr_cnt - w0, mem[16'h00FF]);
    end
    compared++;
    if (pop_data !== 16'h0) begin mismatched++; $display("FAIL reset_popdata: got %h expected 0000", pop_data); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    start = 1'b0; op = 3'b0; wdata = 16'h0; load_addr = 16'h0;
    test_reset();
    test_jump();
    test_fetch();
    test_push();
    test_pop_ignore_start();
    test_wrap_fetch();
    test_nop();
    test_reset_mid_push();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
